// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-issue decode stage with valid/ready handshakes and MUL stall
module decode_stage #(
   parameter int OPW       = 3,
   parameter int RW        = 3,
   parameter int IMMW      = 8,
   parameter int MUL_STALL = 2,
   parameter int CNTW      = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [OPW+2*RW+IMMW-1:0]  instr,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic                      out_ready,
   output logic                      out_valid,
   output logic [1:0]                ALUFunc,
   output logic                      imm,
   output logic                      write,
   output logic [RW-1:0]             rd,
   output logic [RW-1:0]             rs,
   output logic [IMMW-1:0]           imm_val,
   output logic                      illegal,
   output logic                      err,
   output logic [CNTW-1:0]           issue_cnt
);

   localparam int INSTR_W = OPW + 2*RW + IMMW;
   localparam int SCW     = (MUL_STALL > 0) ? $clog2(MUL_STALL + 1) : 1;

   typedef enum logic {RUN, STALL} state_t;

   state_t           state_q, state_d;
   logic [SCW-1:0]   stall_cnt_q, stall_cnt_d;

   logic             out_valid_q, out_valid_d;
   logic [1:0]       alu_q, alu_d;
   logic             imm_q, imm_d;
   logic             write_q, write_d;
   logic [RW-1:0]    rd_q, rd_d;
   logic [RW-1:0]    rs_q, rs_d;
   logic [IMMW-1:0]  imm_val_q, imm_val_d;
   logic             illegal_q, illegal_d;
   logic             err_q, err_d;
   logic [CNTW-1:0]  issue_cnt_q, issue_cnt_d;

   logic [OPW-1:0]   op_w;
   logic             op_hi_nz;
   logic [1:0]       dec_alu;
   logic             dec_imm;
   logic             dec_write;
   logic             dec_ill;
   logic             dec_mul;
   logic             accept;
   logic             out_hs;

   assign op_w     = instr[INSTR_W-1 -: OPW];
   // Opcode bits above bit 2 only exist for OPW>3; shifting keeps OPW==3 legal.
   assign op_hi_nz = (op_w >> 3) != {OPW{1'b0}};

   assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign out_hs   = out_valid_q && out_ready;

   // Opcode decode table; anything outside the eight base opcodes is illegal.
   always_comb begin
      dec_alu   = 2'b00;
      dec_imm   = 1'b0;
      dec_write = 1'b0;
      dec_ill   = 1'b0;
      dec_mul   = 1'b0;
      if (op_hi_nz) begin
         dec_ill = 1'b1;
      end else begin
         case (op_w[2:0])
            3'd0: ;
            3'd1: dec_write = 1'b1;
            3'd2: begin dec_imm = 1'b1; dec_write = 1'b1; end
            3'd3: begin dec_alu = 2'b01; dec_write = 1'b1; end
            3'd4: begin dec_alu = 2'b01; dec_imm = 1'b1; dec_write = 1'b1; end
            3'd5: begin dec_alu = 2'b10; dec_write = 1'b1; dec_mul = 1'b1; end
            3'd6: begin dec_alu = 2'b10; dec_imm = 1'b1; dec_write = 1'b1; dec_mul = 1'b1; end
            default: dec_ill = 1'b1;
         endcase
      end
   end

   // Stall FSM next state: a MUL closes the input for MUL_STALL cycles.
   always_comb begin
      state_d     = state_q;
      stall_cnt_d = stall_cnt_q;
      case (state_q)
         RUN: begin
            if (accept && dec_mul && (MUL_STALL > 0)) begin
               stall_cnt_d = SCW'(MUL_STALL);
               state_d     = STALL;
            end
         end
         STALL: begin
            stall_cnt_d = stall_cnt_q - SCW'(1);
            if (stall_cnt_q == SCW'(1)) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d     = RUN;
            stall_cnt_d = '0;
         end
      endcase
   end

   // Stall FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= RUN;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Output register next state: load on accept, drop valid on a bare handshake.
   always_comb begin
      out_valid_d = out_valid_q;
      alu_d       = alu_q;
      imm_d       = imm_q;
      write_d     = write_q;
      rd_d        = rd_q;
      rs_d        = rs_q;
      imm_val_d   = imm_val_q;
      illegal_d   = illegal_q;
      err_d       = err_q;
      issue_cnt_d = issue_cnt_q;
      if (out_hs) begin
         issue_cnt_d = issue_cnt_q + CNTW'(1);
         out_valid_d = 1'b0;
      end
      if (accept) begin
         out_valid_d = 1'b1;
         alu_d       = dec_alu;
         imm_d       = dec_imm;
         write_d     = dec_write;
         rd_d        = instr[IMMW+2*RW-1 -: RW];
         rs_d        = instr[IMMW+RW-1 -: RW];
         imm_val_d   = instr[IMMW-1:0];
         illegal_d   = dec_ill;
         err_d       = err_q | dec_ill;
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         alu_q       <= 2'b00;
         imm_q       <= 1'b0;
         write_q     <= 1'b0;
         rd_q        <= '0;
         rs_q        <= '0;
         imm_val_q   <= '0;
         illegal_q   <= 1'b0;
         err_q       <= 1'b0;
         issue_cnt_q <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         alu_q       <= alu_d;
         imm_q       <= imm_d;
         write_q     <= write_d;
         rd_q        <= rd_d;
         rs_q        <= rs_d;
         imm_val_q   <= imm_val_d;
         illegal_q   <= illegal_d;
         err_q       <= err_d;
         issue_cnt_q <= issue_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign ALUFunc   = alu_q;
   assign imm       = imm_q;
   assign write     = write_q;
   assign rd        = rd_q;
   assign rs        = rs_q;
   assign imm_val   = imm_val_q;
   assign illegal   = illegal_q;
   assign err       = err_q;
   assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a transaction-level model
module tb_decode_stage;

   localparam int OPW = 4, RW = 3, IMMW = 8, MUL_STALL = 2, CNTW = 4;
   localparam int IW  = OPW + 2*RW + IMMW;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [IW-1:0]   instr = '0;
   logic            in_valid = 1'b0;
   logic            out_ready = 1'b0;
   logic            in_ready, out_valid, imm, write, illegal, err;
   logic [1:0]      ALUFunc;
   logic [RW-1:0]   rd, rs;
   logic [IMMW-1:0] imm_val;
   logic [CNTW-1:0] issue_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // model of the architecturally visible state
   logic            m_valid, m_imm, m_wr, m_ill, m_err;
   logic [1:0]      m_alu;
   logic [2:0]      m_rd, m_rs;
   logic [7:0]      m_iv;
   int              m_cnt, m_stall;

   decode_stage #(.OPW(OPW), .RW(RW), .IMMW(IMMW), .MUL_STALL(MUL_STALL), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid), .in_ready(in_ready),
      .out_ready(out_ready), .out_valid(out_valid), .ALUFunc(ALUFunc), .imm(imm),
      .write(write), .rd(rd), .rs(rs), .imm_val(imm_val), .illegal(illegal),
      .err(err), .issue_cnt(issue_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [IW-1:0] mk(input int op, input int d, input int s, input int iv);
      logic [3:0] o4; logic [2:0] d3, s3; logic [7:0] i8;
      o4 = op[3:0]; d3 = d[2:0]; s3 = s[2:0]; i8 = iv[7:0];
      return {o4, d3, s3, i8};
   endfunction

   // reference decode table: {alu[1:0], imm, write, illegal}
   function automatic logic [4:0] ref_dec(input logic [3:0] op);
      case (op)
         4'd0: return 5'b00_0_0_0;
         4'd1: return 5'b00_0_1_0;
         4'd2: return 5'b00_1_1_0;
         4'd3: return 5'b01_0_1_0;
         4'd4: return 5'b01_1_1_0;
         4'd5: return 5'b10_0_1_0;
         4'd6: return 5'b10_1_1_0;
         default: return 5'b00_0_0_1;
      endcase
   endfunction

   function automatic logic [24:0] obs();
      return {out_valid, ALUFunc, imm, write, rd, rs, imm_val, illegal, err, issue_cnt};
   endfunction

   function automatic logic [24:0] expv();
      return {m_valid, m_alu, m_imm, m_wr, m_rd, m_rs, m_iv, m_ill, m_err, m_cnt[3:0]};
   endfunction

   function automatic logic m_ready();
      return (m_stall == 0) && (!m_valid || out_ready);
   endfunction

   task automatic model_clear();
      m_valid = 0; m_imm = 0; m_wr = 0; m_ill = 0; m_err = 0;
      m_alu = 0; m_rd = 0; m_rs = 0; m_iv = 0; m_cnt = 0; m_stall = 0;
   endtask

   task automatic drive(input logic v, input logic [IW-1:0] ins, input logic r);
      in_valid = v; instr = ins; out_ready = r;
      #1;
   endtask

   // advance one clock: update the model from the current inputs, then let the DUT take the edge
   task automatic step();
      logic acc, hs;
      logic [4:0] d;
      logic [3:0] op;
      acc = in_valid && m_ready();
      hs  = m_valid && out_ready;
      op  = instr[IW-1 -: 4];
      if (hs) m_cnt = (m_cnt + 1) % 16;
      if (m_stall > 0) m_stall = m_stall - 1;
      else if (acc && (op == 4'd5 || op == 4'd6)) m_stall = MUL_STALL;
      if (acc) begin
         d = ref_dec(op);
         {m_alu, m_imm, m_wr, m_ill} = d;
         m_rd = instr[IMMW+2*RW-1 -: RW];
         m_rs = instr[IMMW+RW-1 -: RW];
         m_iv = instr[IMMW-1:0];
         m_valid = 1;
         m_err = m_err | d[0];
      end else if (hs) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1; in_valid = 0; out_ready = 0; instr = '0;
      #1;
      model_clear();
      @(posedge clk);
      #1;
      reset = 0;
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if (obs() !== 25'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %h want %h", obs(), 25'd0);
      end
      @(posedge clk); #1;
      reset = 0;
      model_clear();
      #1;
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_opcode_sweep();
      for (int op = 0; op < 8; op++) begin
         int guard = 0;
         logic acc = 0;
         while (!acc && guard < 10) begin
            drive(1, mk(op, 5, 2, 8'h3C), 1);
            n_cmp++;
            if (in_ready !== m_ready()) begin
               n_bad++; $display("FAIL sweep_in_ready op%0d: got %b want %b", op, in_ready, m_ready());
            end
            acc = m_ready();
            step();
            n_cmp++;
            if (obs() !== expv()) begin
               n_bad++; $display("FAIL sweep_out op%0d: got %h want %h", op, obs(), expv());
            end
            guard++;
         end
         n_cmp++;
         if (!acc || rd !== 3'd5 || rs !== 3'd2 || imm_val !== 8'h3C || err !== (op == 7)) begin
            n_bad++;
            $display("FAIL sweep_fields op%0d: got acc=%b rd=%0d rs=%0d imm=%h err=%b want acc=1 rd=5 rs=2 imm=3c err=%b",
                     op, acc, rd, rs, imm_val, err, op == 7);
         end
      end
      drive(0, '0, 1); step(); step(); step();
   endtask

   task automatic test_mul_stall();
      logic exp_rdy [3];
      exp_rdy[0] = 0; exp_rdy[1] = 0; exp_rdy[2] = 1;
      drive(1, mk(5, 1, 3, 8'h11), 1);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++; $display("FAIL mul_accept_ready: got %b want 1", in_ready);
      end
      step();
      for (int k = 0; k < 3; k++) begin
         drive(1, mk(1, 4, 6, 8'h22), 1);
         n_cmp++;
         if (in_ready !== exp_rdy[k] || in_ready !== m_ready()) begin
            n_bad++; $display("FAIL mul_stall_t+%0d: got %b want %b", k + 1, in_ready, exp_rdy[k]);
         end
         step();
      end
      n_cmp++;
      if (obs() !== expv() || ALUFunc !== 2'b00 || write !== 1'b1 || rd !== 3'd4) begin
         n_bad++; $display("FAIL mul_then_add: got %h want %h", obs(), expv());
      end
      drive(0, '0, 1); step();
   endtask

   task automatic test_backpressure();
      logic [24:0] snap;
      drive(1, mk(2, 7, 1, 8'hA5), 1);
      step();
      snap = obs();
      for (int k = 0; k < 4; k++) begin
         drive(1, mk(3, 2, 2, 8'h5A), 0);
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_bad++; $display("FAIL bp_in_ready%0d: got %b want 0", k, in_ready);
         end
         step();
         n_cmp++;
         if (obs() !== snap || obs() !== expv()) begin
            n_bad++; $display("FAIL bp_stable%0d: got %h want %h", k, obs(), snap);
         end
      end
      drive(1, mk(3, 2, 2, 8'h5A), 1);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
      end
      step();
      n_cmp++;
      if (obs() !== expv() || out_valid !== 1'b1 || ALUFunc !== 2'b01 || imm !== 1'b0 ||
          issue_cnt !== snap[3:0] + 4'd1) begin
         n_bad++; $display("FAIL bp_replace: got %h want %h", obs(), expv());
      end
      drive(0, '0, 1); step();
   endtask

   task automatic test_cnt_wrap();
      logic saw15, saw_wrap;
      saw15 = 0; saw_wrap = 0;
      do_reset();
      for (int k = 0; k < 17; k++) begin
         drive(1, mk(1, k, k + 1, k), 1);
         step();
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++; $display("FAIL wrap_b2b%0d: got %h want %h", k, obs(), expv());
         end
         if (issue_cnt === 4'd15) saw15 = 1;
         if (saw15 && issue_cnt === 4'd0) saw_wrap = 1;
      end
      drive(0, '0, 1); step();
      n_cmp++;
      if (issue_cnt !== 4'd1 || !saw15 || !saw_wrap) begin
         n_bad++; $display("FAIL wrap_final: got cnt=%0d saw15=%b wrap=%b want cnt=1 saw15=1 wrap=1",
                           issue_cnt, saw15, saw_wrap);
      end
   endtask

   task automatic test_illegal_wide();
      do_reset();
      drive(1, mk(9, 3, 4, 8'h77), 1);
      step();
      n_cmp++;
      if (illegal !== 1'b1 || write !== 1'b0 || err !== 1'b1 || obs() !== expv()) begin
         n_bad++; $display("FAIL illegal_1001: got %h want %h", obs(), expv());
      end
      drive(1, mk(2, 1, 1, 8'h01), 1);
      step();
      n_cmp++;
      if (illegal !== 1'b0 || imm !== 1'b1 || write !== 1'b1 || ALUFunc !== 2'b00 ||
          err !== 1'b1 || obs() !== expv()) begin
         n_bad++; $display("FAIL addi_0010: got %h want %h", obs(), expv());
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         int op;
         op = ($urandom_range(0, 7) == 0) ? $urandom_range(7, 15) : $urandom_range(0, 6);
         drive($urandom_range(0, 3) != 0, mk(op, $urandom, $urandom, $urandom), $urandom_range(0, 2) != 0);
         n_cmp++;
         if (in_ready !== m_ready()) begin
            n_bad++; $display("FAIL rand_in_ready%0d: got %b want %b", k, in_ready, m_ready());
         end
         step();
         n_cmp++;
         if (obs() !== expv()) begin
            n_bad++; $display("FAIL rand_out%0d: got %h want %h", k, obs(), expv());
         end
      end
   endtask

   task automatic test_reset_stall();
      drive(0, '0, 1); step(); step(); step();
      drive(1, mk(6, 2, 3, 8'h44), 1);
      step();
      drive(0, '0, 0);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         n_bad++; $display("FAIL rst_precond: got valid=%b ready=%b want valid=1 ready=0", out_valid, in_ready);
      end
      reset = 1;
      #1;
      n_cmp++;
      if (obs() !== 25'd0) begin
         n_bad++; $display("FAIL rst_async: got %h want %h", obs(), 25'd0);
      end
      model_clear();
      @(posedge clk); #1;
      reset = 0;
      drive(0, '0, 1);
      n_cmp++;
      if (in_ready !== 1'b1) begin
         n_bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready);
      end
      step();
      n_cmp++;
      if (obs() !== 25'd0 || obs() !== expv()) begin
         n_bad++; $display("FAIL rst_no_output: got %h want %h", obs(), 25'd0);
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_opcode_sweep();
      test_mul_stall();
      test_backpressure();
      test_cnt_wrap();
      test_illegal_wide();
      test_random();
      test_reset_stall();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- OPW, 3, opcode field width, minimum 3.
- RW, 3, register address field width.
- IMMW, 8, immediate field width.
- MUL_STALL, 2, cycles in_ready is held low after a MUL/MULI is accepted; 0 means no stall.
- CNTW, 16, width of the issue counter.
- Derived: INSTR_W = OPW + 2*RW + IMMW.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, asynchronous, active-high reset.
- instr, in, INSTR_W, fields from MSB: opcode[OPW], rd[RW], rs[RW], imm[IMMW].
- in_valid, in, 1, instr is valid this cycle.
- in_ready, out, 1, stage accepts instr this cycle.
- out_ready, in, 1, downstream accepts outputs this cycle.
- out_valid, out, 1, registered decode outputs are valid.
- ALUFunc, out, 2, ALU function: 00 add, 01 sub, 10 mul.
- imm, out, 1, operand B is the immediate.
- write, out, 1, register file write enable.
- rd, out, RW, destination register.
- rs, out, RW, source register.
- imm_val, out, IMMW, immediate field.
- illegal, out, 1, the registered instruction is illegal.
- err, out, 1, sticky flag; set when an illegal instruction is accepted.
- issue_cnt, out, CNTW, count of completed output handshakes.

Function
REQ-003 Input accept occurs on a rising edge where in_valid and in_ready are both 1. Output handshake occurs on a rising edge where out_valid and out_ready are both 1.
REQ-004 in_ready is combinational: in_ready = (state==RUN) and (!out_valid or out_ready).
REQ-005 Latency is 1 cycle: decoded fields are registered on the accept edge and out_valid = 1 from that edge.
REQ-006 Without an accept, out_valid clears on an output handshake and otherwise holds. Outputs stay stable while out_valid=1 and out_ready=0.
REQ-007 Decode table (opcode -> ALUFunc, imm, write, illegal):
- 000 NOP -> 00, 0, 0, 0
- 001 ADD -> 00, 0, 1, 0
- 010 ADDI -> 00, 1, 1, 0
- 011 SUB -> 01, 0, 1, 0
- 100 SUBI -> 01, 1, 1, 0
- 101 MUL -> 10, 0, 1, 0
- 110 MULI -> 10, 1, 1, 0
- 111 -> 00, 0, 0, 1
REQ-008 When OPW>3, any opcode with a nonzero bit above bit 2 decodes as illegal: 00, 0, 0, 1.
REQ-009 rd, rs and imm_val are copied unmodified from instr on accept, for every opcode including illegal ones.
REQ-010 err sets on the accept edge of an illegal instruction and stays set until reset.
REQ-011 State machine, two states:
- RUN: accepting MUL/MULI with MUL_STALL>0 loads stall counter with MUL_STALL and enters STALL.
- STALL: counter decrements each cycle; return to RUN on the edge where the counter goes 1->0.
- Net effect: in_ready=0 for exactly MUL_STALL cycles after the accept edge.
REQ-012 When MUL_STALL=0, MUL/MULI never leave RUN. Stall counter width is $clog2(MUL_STALL+1), minimum 1.
REQ-013 Output handshakes proceed during STALL; STALL only gates input acceptance.
REQ-014 issue_cnt increments by 1 on each output handshake and wraps from 2^CNTW-1 to 0.
REQ-015 Accept and output handshake on the same edge: the new instruction is loaded, out_valid stays 1, and issue_cnt increments.
REQ-016 in_valid=1 while in_ready=0: instr is ignored, no state change.

Reset
REQ-017 reset=1 asynchronously forces:
- state to RUN and stall counter to 0;
- out_valid, ALUFunc, imm, write, illegal and err to 0;
- rd, rs, imm_val and issue_cnt to 0.
REQ-018 Reset asserted during STALL or with out_valid=1 discards the pending instruction; nothing is output after release.
REQ-019 in_ready is 1 in the first cycle after reset deasserts.

Verification
REQ-020 Sweep opcodes 0-7 with out_ready=1, rd=5, rs=2, imm=0x3C: each output matches REQ-007 one cycle after accept, rd/rs/imm_val = 5/2/0x3C, err=1 only after opcode 111.
REQ-021 MUL accepted at cycle t with MUL_STALL=2 -> in_ready=0 at t+1 and t+2, 1 at t+3; a following ADD is accepted no earlier than t+3.
REQ-022 out_ready=0 for 4 cycles after ADDI accepted -> outputs stable, in_ready=0; raise out_ready with SUB at the input -> same-edge replace, out_valid stays 1, issue_cnt +1.
REQ-023 CNTW=4, 17 back-to-back ADDs with out_ready=1 -> issue_cnt reaches 15 then wraps to 0, then reads 1.
REQ-024 OPW=4, opcode 1001 -> illegal=1, write=0, err=1; opcode 0010 -> ADDI.
REQ-025 Assert reset mid-STALL with out_valid=1 -> all outputs 0 immediately (asynchronously), in_ready=1 after release, issue_cnt=0.
